main_mem_responder: RTL and testbench
=====================================

// Module: main_mem_responder
// PURPOSE
//  Memory-side responder for CPU load/store traffic: accepts one word request at a time
//  over a valid/ready channel and answers on a valid/ready response channel.
//  Storage is an internal word array; response latency is fixed by parameter.
//  Sits between the memory stage and main memory, as the far end of the memory stage's
//  read/write interface.
// PARAMETERS
//  ADDR_WIDTH    10  word-address bits backed by storage (2**ADDR_WIDTH words)
//  DATA_WIDTH    32  word width
//  RESP_LATENCY  2   cycles from request accept to first resp_valid; legal >= 1
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           async reset, active-low
//  req_valid   in   1           request present
//  req_ready   out  1           responder can accept a request
//  req_write   in   1           1 = store, 0 = load
//  req_addr    in   32          word address
//  req_wdata   in   DATA_WIDTH  store data
//  resp_valid  out  1           response present
//  resp_ready  in   1           requester takes the response
//  resp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors
//  resp_write  out  1           echo of req_write for this response
//  resp_err    out  1           request address was out of range
// BEHAVIOUR
//  - Reset (rst low, async):
//    - state IDLE, latency counter 0, req_ready 0 while rst low.
//    - resp_valid 0, resp_rdata 0, resp_write 0, resp_err 0.
//    - Array contents are NOT cleared; a store already committed persists.
//    - An in-flight transaction is dropped; no response is issued for it.
//  - FSM states and transitions:
//    - IDLE: req_ready=1. On req_valid at a clock edge, capture write/addr/wdata.
//      - Go to RESP if RESP_LATENCY==1, else to WAIT with cnt=RESP_LATENCY-1.
//    - WAIT: req_ready=0. cnt decrements each cycle; when cnt reaches 1, next state is RESP.
//    - RESP: resp_valid=1, req_ready=0. On resp_ready, return to IDLE.
//      - resp_* stay stable while resp_valid && !resp_ready.
//  - Timing:
//    - Accept at edge N gives resp_valid first high in the cycle after edge N+RESP_LATENCY-1,
//      i.e. RESP_LATENCY cycles after accept.
//    - req_ready rises the cycle after the response handshake.
//    - Peak throughput: one request per RESP_LATENCY+1 cycles.
//    - Only one transaction is outstanding; no request is accepted while a response is pending.
//  - Address rule:
//    - In range: req_addr[31:ADDR_WIDTH]==0; index with req_addr[ADDR_WIDTH-1:0].
//    - Out of range: resp_err=1, resp_rdata=0, and the store is suppressed.
//  - Store: array written at the accept edge; the response carries resp_write=1, resp_rdata=0.
//  - Load: data read at the accept edge and held in the response register.
//  - A load issued after a store's response returns the stored value; there are no hazards.
//  - req_valid seen outside IDLE is ignored; the requester must hold it until accepted.
//  - resp_ready outside RESP has no effect.
// TESTING
//  1. Reset, then store 0xDEADBEEF @5, then load @5 (RESP_LATENCY=2, resp_ready=1):
//     - store resp: resp_write=1, resp_rdata=0, exactly 2 cycles after accept.
//     - load resp: 0xDEADBEEF, 2 cycles after accept.
//  2. Backpressure: load @5 with resp_ready=0 for 4 cycles:
//     - resp_valid and resp_rdata held stable throughout; req_ready stays 0.
//     - Handshake when resp_ready=1; req_ready=1 the next cycle.
//  3. Out of range: store 0x1234 @0x400 (ADDR_WIDTH=10):
//     - resp_err=1.
//     - A following load @0x000 returns its prior value, not 0x1234.
//  4. Latency sweep RESP_LATENCY=1,2,5: back-to-back loads with req_valid held high:
//     - accept-to-resp_valid spacing equals RESP_LATENCY.
//     - Accept-to-accept spacing equals RESP_LATENCY+1.
//  5. Reset mid-op: assert rst low during WAIT of a load, release:
//     - no resp_valid ever appears for that load; req_ready=1 in the first cycle after release.
//  6. Reset after committed store @7=0xA5A5A5A5: a load @7 after reset returns 0xA5A5A5A5.

Source files
------------

// File: rtl/main_mem_responder_if.sv
// Request/response channel between the memory stage (master) and main memory (slave).
interface main_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_write;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_write, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_write, resp_err
  );
endinterface

// File: rtl/main_mem_responder.sv
// Single-outstanding word memory responder with fixed response latency.
// Array contents survive reset; only the control path and response registers clear.
module main_mem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int RESP_LATENCY = 2
) (
  input logic                 clk,
  input logic                 rst,
  main_mem_responder_if.slave bus
);
  localparam int CNT_WIDTH = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(RESP_LATENCY - 1);

  // state | meaning
  // IDLE  | ready to accept a request
  // WAIT  | counting down latency; RESP follows when cnt is 1
  // RESP  | response presented, held until resp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  write_q;
  logic                  err_q;
  logic                  accept;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;

  // rst gates ready so nothing is offered while reset is held
  assign bus.req_ready  = rst && (state_q == IDLE);
  assign accept         = bus.req_valid && bus.req_ready;
  assign in_range       = (bus.req_addr[31:ADDR_WIDTH] == '0);
  assign idx            = bus.req_addr[ADDR_WIDTH-1:0];

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_write = write_q;
  assign bus.resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (RESP_LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response fields are captured at accept and held through backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      write_q <= bus.req_write;
      err_q   <= !in_range;
      rdata_q <= (!bus.req_write && in_range) ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus.req_write && in_range) mem[idx] <= bus.req_wdata;
  end
endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: three instances (latency 1, 2, 5) against a word-map model.
module tb_main_mem_responder;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int M  = 1;  // instance with latency 2 used for most scenarios

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]    rq_valid, rq_write, rs_ready;
  logic [31:0]   rq_addr  [3];
  logic [DW-1:0] rq_wdata [3];
  logic [2:0]    ob_req_ready, ob_resp_valid, ob_resp_write, ob_resp_err;
  logic [DW-1:0] ob_rdata [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    main_mem_responder_if #(.DATA_WIDTH(DW)) bus ();
    assign bus.req_valid  = rq_valid[g];
    assign bus.req_write  = rq_write[g];
    assign bus.req_addr   = rq_addr[g];
    assign bus.req_wdata  = rq_wdata[g];
    assign bus.resp_ready = rs_ready[g];
    assign ob_req_ready[g]  = bus.req_ready;
    assign ob_resp_valid[g] = bus.resp_valid;
    assign ob_resp_write[g] = bus.resp_write;
    assign ob_resp_err[g]   = bus.resp_err;
    assign ob_rdata[g]      = bus.resp_rdata;
    main_mem_responder #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .RESP_LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 5))
    ) dut (.clk(clk), .rst(rst), .bus(bus));
  end

  int checks = 0;
  int passes = 0;

  // Reference: committed stores per instance, keyed by instance and word index
  logic [DW-1:0] model [int];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 5);
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> AW) == 0;
  endfunction

  function automatic int key_of(input int k, input logic [31:0] a);
    return k * 65536 + int'(a % (1 << AW));
  endfunction

  function automatic logic [DW-1:0] exp_load(input int k, input logic [31:0] a);
    if (!in_rng(a)) return '0;
    if (model.exists(key_of(k, a))) return model[key_of(k, a)];
    return '0;
  endfunction

  // Drives one request with resp_ready=1 and returns the response and its latency in cycles
  task automatic do_txn(input int k, input bit w, input logic [31:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd, output bit rw, output bit re,
                        output int lat, output bit ok);
    int t0, n;
    ok = 1'b1;
    @(negedge clk);
    rq_valid[k] = 1'b1; rq_write[k] = w; rq_addr[k] = a; rq_wdata[k] = d; rs_ready[k] = 1'b1;
    n = 0;
    while (!ob_req_ready[k] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) ok = 1'b0;
    t0 = cyc + 1;
    if (w && in_rng(a)) model[key_of(k, a)] = d;
    @(negedge clk);
    rq_valid[k] = 1'b0;
    n = 0;
    while (!ob_resp_valid[k] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) ok = 1'b0;
    lat = cyc + 1 - t0;
    rd = ob_rdata[k]; rw = ob_resp_write[k]; re = ob_resp_err[k];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ob_req_ready[k], ob_resp_valid[k], ob_resp_write[k], ob_resp_err[k], ob_rdata[k]} !== '0)
        $display("FAIL reset_outputs[%0d] got rdy=%b vld=%b wr=%b err=%b rdata=%h exp all 0",
                 k, ob_req_ready[k], ob_resp_valid[k], ob_resp_write[k], ob_resp_err[k], ob_rdata[k]);
      else passes++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ob_req_ready[M] !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", ob_req_ready[M]);
    else passes++;
  endtask

  task automatic test_store_load();
    logic [DW-1:0] rd; bit rw, re, ok; int lat;
    logic [31:0] addrs [8];
    do_txn(M, 1'b1, 32'd5, 32'hDEADBEEF, rd, rw, re, lat, ok);
    checks++;
    if ({ok, rw, re, rd} !== {1'b1, 1'b1, 1'b0, 32'h0} || lat != 2)
      $display("FAIL store5 got ok=%b wr=%b err=%b rdata=%h lat=%0d exp 1 1 0 0 lat=2", ok, rw, re, rd, lat);
    else passes++;
    do_txn(M, 1'b0, 32'd5, '0, rd, rw, re, lat, ok);
    checks++;
    if ({ok, rw, re, rd} !== {1'b1, 1'b0, 1'b0, 32'hDEADBEEF} || lat != 2)
      $display("FAIL load5 got ok=%b wr=%b err=%b rdata=%h lat=%0d exp 1 0 0 deadbeef lat=2", ok, rw, re, rd, lat);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 32'($urandom_range(0, (1 << AW) - 1));
      do_txn(M, 1'b1, addrs[i], DW'($urandom), rd, rw, re, lat, ok);
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = addrs[$urandom_range(0, 7)];
      do_txn(M, 1'b0, a, '0, rd, rw, re, lat, ok);
      checks++;
      if (!ok || rd !== exp_load(M, a) || re !== 1'b0 || lat != 2)
        $display("FAIL rand_load @%h got rdata=%h err=%b lat=%0d exp rdata=%h err=0 lat=2",
                 a, rd, re, lat, exp_load(M, a));
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit stable;
    @(negedge clk);
    rq_valid[M] = 1'b1; rq_write[M] = 1'b0; rq_addr[M] = 32'd5; rs_ready[M] = 1'b0;
    n = 0;
    while (!ob_req_ready[M] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    rq_valid[M] = 1'b0;
    n = 0;
    while (!ob_resp_valid[M] && n < 50) begin @(negedge clk); n++; end
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ob_resp_valid[M], ob_req_ready[M], ob_rdata[M]} !== {1'b1, 1'b0, exp_load(M, 32'd5)})
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b rdata=%h exp vld=1 rdy=0 rdata=%h",
                 i, ob_resp_valid[M], ob_req_ready[M], ob_rdata[M], exp_load(M, 32'd5));
      else passes++;
      @(negedge clk);
    end
    rs_ready[M] = 1'b1;
    @(negedge clk);
    checks++;
    if ({ob_req_ready[M], ob_resp_valid[M]} !== 2'b10)
      $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", ob_req_ready[M], ob_resp_valid[M]);
    else passes++;
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] rd, v0; bit rw, re, ok; int lat;
    logic [31:0] hi;
    v0 = DW'($urandom) | 32'h1;
    do_txn(M, 1'b1, 32'h0, v0, rd, rw, re, lat, ok);
    do_txn(M, 1'b1, 32'h400, 32'h1234, rd, rw, re, lat, ok);
    checks++;
    if ({ok, rw, re, rd} !== {1'b1, 1'b1, 1'b1, 32'h0})
      $display("FAIL oor_store got ok=%b wr=%b err=%b rdata=%h exp 1 1 1 0", ok, rw, re, rd);
    else passes++;
    do_txn(M, 1'b0, 32'h0, '0, rd, rw, re, lat, ok);
    checks++;
    if ({ok, re, rd} !== {1'b1, 1'b0, v0})
      $display("FAIL oor_no_alias got err=%b rdata=%h exp err=0 rdata=%h", re, rd, v0);
    else passes++;
    hi = {$urandom_range(1, 32'h003F_FFFF), 10'($urandom)};
    do_txn(M, 1'b0, hi, '0, rd, rw, re, lat, ok);
    checks++;
    if ({ok, rw, re, rd} !== {1'b1, 1'b0, 1'b1, 32'h0})
      $display("FAIL oor_load @%h got wr=%b err=%b rdata=%h exp 0 1 0", hi, rw, re, rd);
    else passes++;
  endtask

  task automatic test_latency_sweep(input int k);
    logic [DW-1:0] rd; bit rw, re, ok; int lat;
    logic [31:0] addrs [4];
    logic [31:0] seq [6];
    int acc [6];
    int issued, got, n, L;
    bit acc_now;
    L = lat_of(k);
    for (int i = 0; i < 4; i++) begin
      addrs[i] = 32'($urandom_range(0, (1 << AW) - 1));
      do_txn(k, 1'b1, addrs[i], DW'($urandom), rd, rw, re, lat, ok);
      checks++;
      if (!ok || lat != L || rw !== 1'b1)
        $display("FAIL sweep_store L=%0d got ok=%b lat=%0d wr=%b exp lat=%0d wr=1", L, ok, lat, rw, L);
      else passes++;
    end
    for (int i = 0; i < 6; i++) seq[i] = addrs[$urandom_range(0, 3)];
    @(negedge clk);
    rq_valid[k] = 1'b1; rq_write[k] = 1'b0; rq_addr[k] = seq[0]; rs_ready[k] = 1'b1;
    issued = 0; got = 0; n = 0; acc_now = 1'b0;
    while (got < 6 && n < 300) begin
      if (ob_resp_valid[k]) begin
        checks++;
        if (ob_rdata[k] !== exp_load(k, seq[got]) || (cyc + 1 - acc[got]) != L)
          $display("FAIL sweep_load L=%0d #%0d got rdata=%h lat=%0d exp rdata=%h lat=%0d",
                   L, got, ob_rdata[k], cyc + 1 - acc[got], exp_load(k, seq[got]), L);
        else passes++;
        got++;
      end
      if (ob_req_ready[k] && rq_valid[k]) begin
        acc[issued] = cyc + 1;
        if (issued > 0) begin
          checks++;
          if (acc[issued] - acc[issued-1] != L + 1)
            $display("FAIL sweep_spacing L=%0d got %0d exp %0d", L, acc[issued] - acc[issued-1], L + 1);
          else passes++;
        end
        acc_now = 1'b1;
      end
      @(negedge clk);
      n++;
      if (acc_now) begin
        issued++;
        if (issued < 6) rq_addr[k] = seq[issued];
        else rq_valid[k] = 1'b0;
        acc_now = 1'b0;
      end
    end
    checks++;
    if (got != 6) $display("FAIL sweep_timeout L=%0d got %0d responses exp 6", L, got);
    else passes++;
    rq_valid[k] = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [DW-1:0] rd; bit rw, re, ok; int lat, n;
    bit seen;
    do_txn(M, 1'b1, 32'd9, DW'($urandom), rd, rw, re, lat, ok);
    @(negedge clk);
    rq_valid[M] = 1'b1; rq_write[M] = 1'b0; rq_addr[M] = 32'd9; rs_ready[M] = 1'b1;
    n = 0;
    while (!ob_req_ready[M] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    rq_valid[M] = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({ob_req_ready[M], ob_resp_valid[M], ob_rdata[M]} !== '0)
      $display("FAIL midop_in_reset got rdy=%b vld=%b rdata=%h exp 0 0 0",
               ob_req_ready[M], ob_resp_valid[M], ob_rdata[M]);
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ob_req_ready[M] !== 1'b1) $display("FAIL midop_release_ready got %b exp 1", ob_req_ready[M]);
    else passes++;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ob_resp_valid[M] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL midop_dropped got resp_valid=1 after reset exp never");
    else passes++;
  endtask

  task automatic test_reset_persist();
    logic [DW-1:0] rd; bit rw, re, ok; int lat;
    do_txn(M, 1'b1, 32'd7, 32'hA5A5A5A5, rd, rw, re, lat, ok);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_txn(M, 1'b0, 32'd7, '0, rd, rw, re, lat, ok);
    checks++;
    if ({ok, re, rd} !== {1'b1, 1'b0, 32'hA5A5A5A5} || lat != 2)
      $display("FAIL persist7 got ok=%b err=%b rdata=%h lat=%0d exp 1 0 a5a5a5a5 lat=2", ok, re, rd, lat);
    else passes++;
  endtask

  initial begin
    rst = 1'b0;
    rq_valid = '0; rq_write = '0; rs_ready = '0;
    for (int k = 0; k < 3; k++) begin rq_addr[k] = '0; rq_wdata[k] = '0; end
    test_reset();
    test_store_load();
    test_backpressure();
    test_out_of_range();
    for (int k = 0; k < 3; k++) test_latency_sweep(k);
    test_reset_mid_op();
    test_reset_persist();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached with %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end
endmodule
